// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, default bus
// address and the status-register layout.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_ACK_SRC   = 2'd2,
    ST_WAIT_DROP = 2'd3
  } irq_state_e;

  localparam logic [7:0]  IRQ_BASE_ADDR_DEFAULT = 8'hF0;
  localparam int unsigned IRQ_VEC_W             = 3;

  // Status byte, low to high: pending[nSrc-1:0], vector[2:0], in_service_valid.
  // Bits beyond the byte are dropped; short layouts are zero-padded.
  function automatic logic [7:0] irq_pack_status(input logic                 insvc,
                                                 input logic [IRQ_VEC_W-1:0] vec,
                                                 input logic [7:0]           pend,
                                                 input int unsigned          nSrc);
    logic [15:0] full;
    full = ({12'd0, insvc, vec} << nSrc) | {8'd0, pend};
    return full[7:0];
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Link between the controller and its priority encoder: the controller supplies
// the pending vector, the encoder returns the winning index and a valid flag.
interface interrupt_controller_if
  import irq_pkg::*;
#(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0]     pending;
  logic [IRQ_VEC_W-1:0] index;
  logic                 valid;

  modport master (output pending, input index, input valid);
  modport slave  (input pending, output index, output valid);
endinterface

// File: rtl/interrupt_controller_prio_enc.sv
// Fixed-priority encoder: the lowest set pending bit wins.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N_SRC = 4
) (
  interrupt_controller_if.slave enc
);

  // Scan from the top down so the lowest index overwrites any higher one.
  always_comb begin
    enc.valid = 1'b0;
    enc.index = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (enc.pending[i]) begin
        enc.valid = 1'b1;
        enc.index = 3'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: maskable per-source pending bits, fixed priority, and a
// four-state handshake between the peripherals and the processor.
module interrupt_controller
  import irq_pkg::*;
#(
  parameter int         N_SRC     = 4,
  parameter logic [7:0] BASE_ADDR = IRQ_BASE_ADDR_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] BUS_INTERRUPTS_RAISE,
  output logic [N_SRC-1:0] BUS_INTERRUPTS_ACK,
  output logic             CPU_IRQ,
  output logic [2:0]       CPU_VECTOR,
  input  logic             CPU_IRQ_ACK,
  input  logic [7:0]       BUS_ADDR,
  inout  wire  [7:0]       BUS_DATA,
  input  logic             BUS_WE
);

  irq_state_e       r_state, w_state_nxt;
  logic [N_SRC-1:0] r_mask, r_pending;
  logic [2:0]       r_vector, r_enc_idx;
  logic             r_enc_valid;
  logic [N_SRC-1:0] w_vec_1h, w_enc_1h, w_set, w_ack_clr, w_wr_data;
  logic             w_mask_wr, w_rd_mask, w_rd_stat, w_withdraw, w_take;
  logic             w_insvc, w_load_vec, w_src_high;
  logic [7:0]       w_rd_data;

  interrupt_controller_if #(.N_SRC(N_SRC)) u_enc_if ();
  assign u_enc_if.pending = r_pending;
  irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (.enc(u_enc_if));

  always_comb begin
    w_vec_1h = '0;
    w_enc_1h = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_vec_1h[i] = (r_vector == 3'(i));
      w_enc_1h[i] = (r_enc_idx == 3'(i));
    end
  end

  assign w_mask_wr  = BUS_WE && (BUS_ADDR == BASE_ADDR);
  assign w_rd_mask  = !BUS_WE && (BUS_ADDR == BASE_ADDR);
  assign w_rd_stat  = !BUS_WE && (BUS_ADDR == 8'(BASE_ADDR + 8'd1));
  assign w_wr_data  = BUS_DATA[N_SRC-1:0];
  assign w_withdraw = w_mask_wr && !(|(w_wr_data & w_vec_1h));
  assign w_src_high = |(BUS_INTERRUPTS_RAISE & w_vec_1h);
  // The encoder output is one cycle old; only act on it if that bit is still pending.
  assign w_take     = r_enc_valid && (|(r_pending & w_enc_1h));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (w_take) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (CPU_IRQ_ACK)     w_state_nxt = ST_ACK_SRC;
        else if (w_withdraw) w_state_nxt = ST_IDLE;
      end
      ST_ACK_SRC:   w_state_nxt = ST_WAIT_DROP;
      ST_WAIT_DROP: if (!w_src_high) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    CPU_IRQ            = (r_state == ST_REQ);
    BUS_INTERRUPTS_ACK = (r_state == ST_ACK_SRC) ? w_vec_1h : '0;
    w_insvc            = (r_state == ST_ACK_SRC) || (r_state == ST_WAIT_DROP);
    w_load_vec         = (r_state == ST_IDLE) && w_take;
    w_ack_clr          = ((r_state == ST_REQ) && CPU_IRQ_ACK) ? w_vec_1h : '0;
  end

  // A source in service cannot re-pend; the acknowledge clear beats a same-edge set.
  assign w_set = BUS_INTERRUPTS_RAISE & r_mask & ~(w_insvc ? w_vec_1h : '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_mask      <= '1;
      r_pending   <= '0;
      r_vector    <= '0;
      r_enc_idx   <= '0;
      r_enc_valid <= 1'b0;
    end else begin
      r_enc_idx   <= u_enc_if.index;
      r_enc_valid <= u_enc_if.valid;
      r_pending   <= (r_pending | w_set) & ~w_ack_clr & (w_mask_wr ? w_wr_data : '1);
      if (w_mask_wr)  r_mask   <= w_wr_data;
      if (w_load_vec) r_vector <= r_enc_idx;
    end
  end

  assign CPU_VECTOR = r_vector;
  assign w_rd_data  = w_rd_mask ? 8'(r_mask)
                                : irq_pack_status(w_insvc, r_vector, 8'(r_pending), N_SRC);
  assign BUS_DATA   = (w_rd_mask || w_rd_stat) ? w_rd_data : 8'hzz;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: hand-computed expectations for the
// handshake, priority, masking, withdrawal, held sources and mid-handshake reset.
module tb_interrupt_controller;
  import irq_pkg::*;

  logic       clk;
  logic       rstN;
  logic [3:0] raise;
  logic [3:0] srcAck;
  logic       cpuIrq;
  logic [2:0] cpuVector;
  logic       cpuIrqAck;
  logic [7:0] busAddr;
  logic       busWe;
  logic       tbDrvEn;
  logic [7:0] tbDrvData;
  wire  [7:0] busData;
  logic [7:0] rdData;

  int vectors     = 0;
  int miscompares = 0;

  assign busData = tbDrvEn ? tbDrvData : 8'hzz;

  interrupt_controller #(.N_SRC(4), .BASE_ADDR(8'hF0)) dut (
    .CLK                  (clk),
    .RESET                (rstN),
    .BUS_INTERRUPTS_RAISE (raise),
    .BUS_INTERRUPTS_ACK   (srcAck),
    .CPU_IRQ              (cpuIrq),
    .CPU_VECTOR           (cpuVector),
    .CPU_IRQ_ACK          (cpuIrqAck),
    .BUS_ADDR             (busAddr),
    .BUS_DATA             (busData),
    .BUS_WE               (busWe)
  );

  // Stand-alone encoder on its own interface instance.
  interrupt_controller_if #(.N_SRC(4)) encIf ();
  irq_prio_enc #(.N_SRC(4)) uEnc (.enc(encIf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic a);
    raise     = r;
    cpuIrqAck = a;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [7:0] addr, input logic [7:0] data);
    busAddr   = addr;
    busWe     = 1'b1;
    tbDrvEn   = 1'b1;
    tbDrvData = data;
    waitCycles(1);
    busWe     = 1'b0;
    tbDrvEn   = 1'b0;
    busAddr   = 8'h00;
  endtask

  task automatic busRead(input logic [7:0] addr, output logic [7:0] data);
    busAddr = addr;
    busWe   = 1'b0;
    tbDrvEn = 1'b0;
    #1;
    data    = busData;
    busAddr = 8'h00;
  endtask

  task automatic checkIrq(input string tag, input logic irq, input logic [2:0] vec, input logic [3:0] ack);
    checkOutput({tag, "_irq"}, 32'(cpuIrq), 32'(irq));
    if (irq) checkOutput({tag, "_vec"}, 32'(cpuVector), 32'(vec));
    checkOutput({tag, "_ack"}, 32'(srcAck), 32'(ack));
  endtask

  initial begin
    rstN = 1'b0; busAddr = 8'h00; busWe = 1'b0; tbDrvEn = 1'b0; tbDrvData = 8'h00;
    applyStimulus(4'b0000, 1'b0);
    encIf.pending = 4'b0000;

    encIf.pending = 4'b1010; #1;
    checkOutput("enc_1010_idx", 32'(encIf.index), 32'd1);
    encIf.pending = 4'b1000; #1;
    checkOutput("enc_1000_idx", 32'(encIf.index), 32'd3);
    encIf.pending = 4'b0000; #1;
    checkOutput("enc_0000_valid", 32'(encIf.valid), 32'd0);

    waitCycles(2);
    checkOutput("rst_irq", 32'(cpuIrq), 32'd0);
    checkOutput("rst_vec", 32'(cpuVector), 32'd0);
    checkOutput("rst_ack", 32'(srcAck), 32'd0);
    rstN = 1'b1;
    busRead(8'hF0, rdData); checkOutput("rst_mask", 32'(rdData), 32'h0F);
    busRead(8'hF1, rdData); checkOutput("rst_status", 32'(rdData), 32'h00);

    // Single source: two-cycle latency, one-cycle acknowledge pulse.
    applyStimulus(4'b0001, 1'b0);
    waitCycles(1); checkIrq("single_e1", 1'b0, 3'd0, 4'b0000);
    busRead(8'hF1, rdData); checkOutput("single_pend", 32'(rdData), 32'h01);
    waitCycles(1); checkIrq("single_e2", 1'b0, 3'd0, 4'b0000);
    waitCycles(1); checkIrq("single_req", 1'b1, 3'd0, 4'b0000);
    waitCycles(2); checkIrq("single_hold", 1'b1, 3'd0, 4'b0000);
    applyStimulus(4'b0001, 1'b1);
    waitCycles(1); checkIrq("single_acksrc", 1'b0, 3'd0, 4'b0001);
    applyStimulus(4'b0001, 1'b0);
    busRead(8'hF1, rdData); checkOutput("single_insvc", 32'(rdData), 32'h80);
    waitCycles(1); checkIrq("single_ackdrop", 1'b0, 3'd0, 4'b0000);
    waitCycles(3); checkIrq("single_held", 1'b0, 3'd0, 4'b0000);
    applyStimulus(4'b0000, 1'b0);
    waitCycles(1);
    busRead(8'hF1, rdData); checkOutput("single_idle", 32'(rdData), 32'h00);
    waitCycles(2);

    // Simultaneous sources 1 and 3, plus a late higher-priority arrival.
    applyStimulus(4'b1010, 1'b0);
    waitCycles(3); checkIrq("sim_req1", 1'b1, 3'd1, 4'b0000);
    busRead(8'hF1, rdData); checkOutput("sim_status", 32'(rdData), 32'h1A);
    applyStimulus(4'b1010, 1'b1);
    waitCycles(1); checkIrq("sim_ack1", 1'b0, 3'd0, 4'b0010);
    applyStimulus(4'b1010, 1'b0);
    waitCycles(1); checkIrq("sim_wait1", 1'b0, 3'd0, 4'b0000);
    applyStimulus(4'b1000, 1'b0);
    waitCycles(1); checkIrq("sim_idle", 1'b0, 3'd0, 4'b0000);
    waitCycles(1); checkIrq("sim_req3", 1'b1, 3'd3, 4'b0000);
    applyStimulus(4'b1001, 1'b0);
    waitCycles(1); checkIrq("sim_nopreempt", 1'b1, 3'd3, 4'b0000);
    applyStimulus(4'b1001, 1'b1);
    waitCycles(1); checkIrq("sim_ack3", 1'b0, 3'd0, 4'b1000);
    applyStimulus(4'b1001, 1'b0);
    waitCycles(1); checkIrq("sim_wait3", 1'b0, 3'd0, 4'b0000);
    applyStimulus(4'b0001, 1'b0);
    waitCycles(1);
    waitCycles(1); checkIrq("sim_req0", 1'b1, 3'd0, 4'b0000);
    applyStimulus(4'b0001, 1'b1);
    waitCycles(1); checkIrq("sim_ack0", 1'b0, 3'd0, 4'b0001);
    applyStimulus(4'b0000, 1'b0);
    waitCycles(3);

    // Acknowledge outside REQ is ignored.
    applyStimulus(4'b0000, 1'b1);
    waitCycles(1); checkIrq("stray_ack", 1'b0, 3'd0, 4'b0000);
    applyStimulus(4'b0000, 1'b0);

    // Masked source never requests.
    busWrite(8'hF0, 8'h0E);
    applyStimulus(4'b0001, 1'b0);
    waitCycles(4); checkIrq("mask_quiet", 1'b0, 3'd0, 4'b0000);
    busRead(8'hF1, rdData); checkOutput("mask_pend", 32'(rdData), 32'h00);
    busRead(8'hF0, rdData); checkOutput("mask_read", 32'(rdData), 32'h0E);
    applyStimulus(4'b0000, 1'b0);

    // Withdrawal of vector 2 by masking while in REQ.
    busWrite(8'hF0, 8'h0F);
    applyStimulus(4'b0100, 1'b0);
    waitCycles(3); checkIrq("wd_req2", 1'b1, 3'd2, 4'b0000);
    busWrite(8'hF0, 8'h0B);
    checkIrq("wd_drop", 1'b0, 3'd0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      waitCycles(1); checkIrq("wd_noack", 1'b0, 3'd0, 4'b0000);
    end
    busRead(8'hF1, rdData); checkOutput("wd_status", 32'(rdData), 32'h20);
    applyStimulus(4'b0000, 1'b0);

    // Held source stays blocked until it drops for a cycle.
    busWrite(8'hF0, 8'h07);
    applyStimulus(4'b0010, 1'b0);
    waitCycles(3); checkIrq("held_req", 1'b1, 3'd1, 4'b0000);
    applyStimulus(4'b0010, 1'b1);
    waitCycles(1); checkIrq("held_ack", 1'b0, 3'd0, 4'b0010);
    applyStimulus(4'b0010, 1'b0);
    for (int i = 0; i < 20; i++) begin
      waitCycles(1); checkOutput("held_noirq", 32'(cpuIrq), 32'd0);
    end
    applyStimulus(4'b0000, 1'b0);
    waitCycles(1);
    applyStimulus(4'b0010, 1'b0);
    waitCycles(2); checkIrq("held_relat", 1'b0, 3'd0, 4'b0000);
    waitCycles(1); checkIrq("held_rereq", 1'b1, 3'd1, 4'b0000);
    applyStimulus(4'b0010, 1'b1);
    waitCycles(1); checkIrq("held_ack2", 1'b0, 3'd0, 4'b0010);
    applyStimulus(4'b0010, 1'b0);

    // Reset asserted during ACK_SRC.
    rstN = 1'b0; #1;
    checkOutput("midrst_irq", 32'(cpuIrq), 32'd0);
    checkOutput("midrst_vec", 32'(cpuVector), 32'd0);
    checkOutput("midrst_ack", 32'(srcAck), 32'd0);
    busRead(8'hF0, rdData); checkOutput("midrst_mask", 32'(rdData), 32'h0F);
    busRead(8'hF1, rdData); checkOutput("midrst_status", 32'(rdData), 32'h00);
    applyStimulus(4'b0000, 1'b0);
    waitCycles(2);

    // First edge after release samples RAISE normally.
    rstN = 1'b1;
    applyStimulus(4'b0001, 1'b0);
    waitCycles(2); checkIrq("post_e2", 1'b0, 3'd0, 4'b0000);
    waitCycles(1); checkIrq("post_req", 1'b1, 3'd0, 4'b0000);
    applyStimulus(4'b0000, 1'b0);
    waitCycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
